approx_ha_array_mul_pipe: RTL and testbench

//  Parametrised, pipelined successor of the unsigned HA-array partial-product stage. Forms WIDTH x WIDTH

---
 rtl/approx_ha_array_mul_pipe.sv | 133 +++++++++++++
 tb/tb_approx_ha_array_mul_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/approx_ha_array_mul_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier built from half-adder row pairs.
// The low pair columns can be swapped for OR-only sums (carry dropped). The
// exact product runs alongside, so every result also carries its error.
// Three register stages with a valid/ready handshake; bubbles collapse.

// One row pair: rows 2k (x_lo) and 2k+1 (x_hi) compressed into t/b_vec.
module approx_ha_pair #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0] y,
  input  logic             x_lo,
  input  logic             x_hi,
  input  logic             approx_en,
  output logic [WIDTH:0]   t,
  output logic [WIDTH-2:0] b_vec
);
  // Column-wise half adders; approximated columns OR the bits and lose the carry.
  always_comb begin
    t     = '0;
    b_vec = '0;
    t[0]  = y[0] & x_lo;
    for (int c = 1; c < WIDTH; c++) begin
      if (approx_en && (c < APPROX_COLS)) begin
        t[c] = (y[c] & x_lo) | (y[c-1] & x_hi);
      end else begin
        t[c] = (y[c] & x_lo) ^ (y[c-1] & x_hi);
        if (c == WIDTH-1) t[WIDTH]  = (y[c] & x_lo) & (y[c-1] & x_hi);
        else              b_vec[c-1] = (y[c] & x_lo) & (y[c-1] & x_hi);
      end
    end
    // Top bit of the odd row has no partner; it rides in the b_vec MSB.
    b_vec[WIDTH-2] = y[WIDTH-1] & x_hi;
  end
endmodule

module approx_ha_array_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [2*WIDTH-1:0] err
);
  localparam int NP = WIDTH / 2;
  localparam int PW = WIDTH + 2;

  logic [3:1] vld_pipe;
  logic [3:1] ld;
  logic       accept;

  // A stage loads when empty or when its successor moves on this cycle.
  assign ld[3]     = ~vld_pipe[3] | out_ready;
  assign ld[2]     = ~vld_pipe[2] | ld[3];
  assign ld[1]     = ~vld_pipe[1] | ld[2];
  assign in_ready  = rst_n & ld[1];
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[3];

  // Stage 1 combinational: per-pair half-adder compression
  logic [NP-1:0][WIDTH:0]   t_c;
  logic [NP-1:0][WIDTH-2:0] bv_c;
  logic [NP-1:0][WIDTH:0]   t_q;
  logic [NP-1:0][WIDTH-2:0] bv_q;
  logic [WIDTH-1:0]         x_q, y_q;

  for (genvar k = 0; k < NP; k++) begin : g_pair
    approx_ha_pair #(.WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS)) u_pair (
      .y         (y),
      .x_lo      (x[2*k]),
      .x_hi      (x[2*k+1]),
      .approx_en (approx_en),
      .t         (t_c[k]),
      .b_vec     (bv_c[k])
    );
  end

  // Stage 2 combinational: pair values t + (b_vec << 2)
  logic [NP-1:0][PW-1:0] pv_c;
  logic [NP-1:0][PW-1:0] pv_q;
  logic [2*WIDTH-1:0]    exact_q;

  for (genvar k = 0; k < NP; k++) begin : g_pv
    assign pv_c[k] = {1'b0, t_q[k]} + {1'b0, bv_q[k], 2'b00};
  end

  // Stage 3 combinational: weighted sum of pairs; fits in 2*WIDTH bits
  logic [2*WIDTH-1:0] sum_c;
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NP; k++)
      sum_c = sum_c + ({{(WIDTH-2){1'b0}}, pv_q[k]} << (2*k));
  end

  // Valid bits and output registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      prod     <= '0;
      err      <= '0;
    end else begin
      if (ld[1]) vld_pipe[1] <= accept;
      if (ld[2]) vld_pipe[2] <= vld_pipe[1];
      if (ld[3]) vld_pipe[3] <= vld_pipe[2];
      if (ld[3] && vld_pipe[2]) begin
        prod <= sum_c;
        err  <= exact_q - sum_c;
      end
    end
  end

  // Stage 1/2 data; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      t_q  <= t_c;
      bv_q <= bv_c;
      x_q  <= x;
      y_q  <= y;
    end
    if (ld[2] && vld_pipe[1]) begin
      pv_q    <= pv_c;
      exact_q <= {{WIDTH{1'b0}}, x_q} * {{WIDTH{1'b0}}, y_q};
    end
  end
endmodule

// File: tb/tb_approx_ha_array_mul_pipe.sv
// Directed and randomized checks for approx_ha_array_mul_pipe (WIDTH=8, APPROX_COLS=4).
module tb_approx_ha_array_mul_pipe;
  localparam int W  = 8;
  localparam int AC = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, approx_en, out_valid, out_ready;
  logic [W-1:0]   x, y;
  logic [2*W-1:0] prod, err;
  int             total = 0;
  int             bad   = 0;

  approx_ha_array_mul_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod), .err(err)
  );

  always #5 clk = ~clk;

  // Loss model: each approximated column with both inputs set loses 2^c of the pair.
  function automatic logic [2*W-1:0] model_loss(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                                input logic ap);
    logic [2*W-1:0] l;
    logic [2*W-1:0] one;
    l   = '0;
    one = 1;
    if (ap)
      for (int k = 0; k < W/2; k++)
        for (int c = 1; c < AC && c < W; c++)
          if (yv[c] & xv[2*k] & yv[c-1] & xv[2*k+1]) l = l + (one << (c + 2*k));
    return l;
  endfunction

  // Send one beat with out_ready=1 and report result plus accept-to-valid latency.
  task automatic do_beat(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic ap,
                         output logic [2*W-1:0] p, output logic [2*W-1:0] e, output int lat);
    int n;
    @(negedge clk);
    x = xv; y = yv; approx_en = ap; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin @(negedge clk); #1; lat++; end
    p = prod; e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; approx_en = 1'b0; x = 8'h12; y = 8'h34;
    repeat (3) @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (prod !== '0 || err !== '0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", prod, err); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
    repeat (5) begin
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_dropped_beat out_valid=%b want=0", out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]   tx [7] = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h01, 8'h00, 8'h77};
    logic [W-1:0]   ty [7] = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'hA5, 8'h5A, 8'h00};
    logic           ta [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] tp [7] = '{16'hF95B, 16'hFE01, 16'd7, 16'd9, 16'h00A5, 16'h0000, 16'h0000};
    logic [2*W-1:0] te [7] = '{16'h04A6, 16'h0000, 16'd2, 16'd0, 16'h0000, 16'h0000, 16'h0000};
    logic [2*W-1:0] p, e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_beat(tx[i], ty[i], ta[i], p, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat); end
      total++; if (p !== tp[i]) begin bad++; $display("FAIL dir%0d_prod got=%h want=%h", i, p, tp[i]); end
      total++; if (e !== te[i]) begin bad++; $display("FAIL dir%0d_err got=%h want=%h", i, e, te[i]); end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0]   sx [4] = '{8'hFF, 8'hFF, 8'h03, 8'h03};
    logic           sa [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2*W-1:0] sp [4] = '{16'hF95B, 16'hFE01, 16'd7, 16'd9};
    logic [2*W-1:0] se [4] = '{16'h04A6, 16'h0000, 16'd2, 16'd0};
    int acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      x = sx[acc]; y = sx[acc]; approx_en = sa[acc];
      #1;
      if (in_ready) acc++;
    end
    total++; if (acc !== 3) begin bad++; $display("FAIL stall_accepted got=%0d want=3", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || prod !== sp[0] || err !== se[0]) begin
        bad++; $display("FAIL stall_hold v=%b prod=%h err=%h want 1/%h/%h", out_valid, prod, err, sp[0], se[0]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (acc < 4);
      if (acc < 4) begin x = sx[acc]; y = sx[acc]; approx_en = sa[acc]; end
      #1;
      if (in_valid && in_ready) acc++;
      total++;
      if (out_valid !== 1'b1 || prod !== sp[c] || err !== se[c]) begin
        bad++; $display("FAIL drain%0d v=%b prod=%h err=%h want 1/%h/%h", c, out_valid, prod, err, sp[c], se[c]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (acc !== 4 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_end acc=%0d v=%b want 4/0", acc, out_valid); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] qp[$], qe[$];
    logic [2*W-1:0] ex, lo;
    int sent = 0, recv = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      x         = W'($urandom);
      y         = W'($urandom);
      approx_en = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (qp.size() == 0) begin
          bad++; $display("FAIL rnd_extra_beat prod=%h err=%h want none", prod, err);
        end else begin
          if (prod !== qp[0] || err !== qe[0]) begin
            bad++; $display("FAIL rnd_beat%0d prod=%h err=%h want %h/%h", recv, prod, err, qp[0], qe[0]);
          end
          void'(qp.pop_front()); void'(qe.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        ex = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        lo = model_loss(x, y, approx_en);
        qp.push_back(ex - lo);
        qe.push_back(lo);
        sent++;
      end
      if (sent == 10000 && qp.size() == 0) break;
    end
    in_valid = 1'b0;
    total++; if (sent !== 10000 || recv !== 10000) begin bad++; $display("FAIL rnd_count sent=%0d recv=%0d want 10000/10000", sent, recv); end
  endtask

  task automatic test_reset_flush();
    logic [2*W-1:0] p, e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; x = 8'hFF; y = 8'hFF; approx_en = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || prod !== '0 || err !== '0) begin
      bad++; $display("FAIL flush_state v=%b prod=%h err=%h want 0/0/0", out_valid, prod, err);
    end
    repeat (4) begin
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale v=%b want 0", out_valid); end
    end
    do_beat(8'h03, 8'h03, 1'b1, p, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL flush_next_latency got=%0d want=3", lat); end
    total++; if (p !== 16'd7 || e !== 16'd2) begin bad++; $display("FAIL flush_next_data got=%h/%h want 0007/0002", p, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_stall();
    test_random();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
